wb_pipe_buf: RTL and testbench
==============================

WB_PIPE_BUF -- requirements
Module: wb_pipe_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of the data, HI and LO payload fields.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning width of the destination register address.
REQ-003 SHALL have parameter DEPTH, default 2, meaning number of buffer entries; legal values are 2 and 4.
REQ-004 SHALL have port: clk  input  1  the one clock; all state is updated on its rising edge.
REQ-005 SHALL have port: rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port: flush  input  1  discard all buffered entries.
REQ-007 SHALL have port: in_valid  input  1  upstream offers an entry.
REQ-008 SHALL have port: in_ready  output  1  the buffer can accept an entry this cycle.
REQ-009 SHALL have ports: in_wd  input  ADDR_W; in_wreg  input  1; in_wdata  input  DATA_W; in_hi  input  DATA_W; in_lo  input  DATA_W; in_whilo  input  1; all form the memory-stage result.
REQ-010 SHALL have port: out_valid  output  1  head entry is presented to write-back.
REQ-011 SHALL have port: out_ready  input  1  write-back consumes the head entry.
REQ-012 SHALL have ports: out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo, each an output of the same width as its in_ counterpart, carrying the head entry.
REQ-013 SHALL have port: occupancy  output  3  number of valid entries, range 0..DEPTH.
REQ-014 SHALL have port: stall_cnt  output  16  count of backpressured cycles.

Function
REQ-015 SHALL store entries in a DEPTH-entry circular buffer with read and write pointers that wrap modulo DEPTH.
REQ-016 SHALL drive in_ready = (occupancy < DEPTH) && !flush, combinationally from registered state; a full buffer SHALL NOT accept an entry even when a pop occurs in the same cycle.
REQ-017 SHALL push the in_ payload on every edge where in_valid && in_ready.
REQ-018 SHALL pop the head entry on every edge where out_valid && out_ready && !flush.
REQ-019 SHALL leave occupancy unchanged on a simultaneous push and pop, with both pointers advancing.
REQ-020 SHALL drive out_valid = (occupancy != 0); latency from accept to out_valid is exactly 1 cycle when the buffer is empty.
REQ-021 SHALL force out_wd = 0 (NOP address), out_wreg = 0, out_wdata = out_hi = out_lo = 0 and out_whilo = 0 while out_valid is 0, so that an empty buffer presents a bubble.
REQ-022 SHALL give flush priority over push and pop: on an edge with flush = 1, occupancy becomes 0, both pointers return to 0, and in_valid is ignored.
REQ-023 SHALL keep the head payload stable while out_valid && !out_ready.
REQ-024 SHALL increment stall_cnt on each edge where out_valid && !out_ready, saturate it at 16'hFFFF, and leave it unchanged by flush.
REQ-025 SHALL not constrain out_ready and in_valid relative to each other; no combinational path SHALL exist from out_ready to in_ready.

Reset
REQ-026 SHALL, while rst = 0 and independent of clk, set occupancy = 0, both pointers = 0, and stall_cnt = 0, with all out_ payload fields at their bubble values.
REQ-027 SHALL, when reset is asserted mid-transfer, discard buffered entries and hold in_ready = 0 while rst = 0.
REQ-028 SHALL resume normal operation on the first rising clk edge after rst returns to 1.

Structure
REQ-029 SHALL take the NOP register address, the zero word, the write enable/disable values and the entry record type (wd, wreg, wdata, hi, lo, whilo) from the shared defines package.
REQ-030 SHALL be implemented as one module with no sub-module; buffer storage and pointer control are inline.

Verification
REQ-031 SHALL cover single pass: push {wd=5, wdata=0x1234, wreg=1} with out_ready = 1 -> out_valid for exactly one cycle on the next cycle with the same values, then bubble outputs.
REQ-032 SHALL cover backpressure: out_ready = 0 with 3 pushes at DEPTH=2 -> occupancy 2, in_ready = 0, third entry not accepted, stall_cnt increments every cycle, head stable.
REQ-033 SHALL cover full simultaneous push/pop: occupancy 2, in_valid = 1, out_ready = 1 -> pop only, occupancy becomes 1.
REQ-034 SHALL cover flush with in_valid = 1 at occupancy 2 -> next cycle occupancy 0, out_valid = 0, offered entry dropped, stall_cnt held.
REQ-035 SHALL cover wrap-around: 10 back-to-back entries with wdata 1..10 at DEPTH=4 under random out_ready -> output order 1..10 with no loss and no duplicates.
REQ-036 SHALL cover async reset: assert rst = 0 between clk edges at occupancy 2 -> occupancy 0, out_wreg = 0 and stall_cnt = 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/wb_pipe_buf_pkg.sv
// Shared write-back defines: NOP address, zero word, write enables
// and the memory-stage result record.
package wb_pipe_buf_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    localparam logic [WB_ADDR_W-1:0] NOP_REG_ADDR  = '0;
    localparam logic [WB_DATA_W-1:0] ZERO_WORD     = '0;
    localparam logic                 WRITE_ENABLE  = 1'b1;
    localparam logic                 WRITE_DISABLE = 1'b0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] wd;
        logic                 wreg;
        logic [WB_DATA_W-1:0] wdata;
        logic [WB_DATA_W-1:0] hi;
        logic [WB_DATA_W-1:0] lo;
        logic                 whilo;
    } wb_entry_t;

endpackage

// File: rtl/wb_pipe_buf.sv
// MEM->WB skid buffer: DEPTH-entry circular queue that presents a
// bubble when empty and counts backpressured cycles.
module wb_pipe_buf
    import wb_pipe_buf_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_wd,
    input  logic              in_wreg,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [DATA_W-1:0] in_hi,
    input  logic [DATA_W-1:0] in_lo,
    input  logic              in_whilo,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_wd,
    output logic              out_wreg,
    output logic [DATA_W-1:0] out_wdata,
    output logic [DATA_W-1:0] out_hi,
    output logic [DATA_W-1:0] out_lo,
    output logic              out_whilo,
    output logic [2:0]        occupancy,
    output logic [15:0]       stall_cnt
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;

    // Same field layout as wb_entry_t, resized to this instance.
    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              whilo;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [2:0]         occ_q, occ_d;
    logic [15:0]        stall_q, stall_d;
    logic               full;
    logic               push;
    logic               pop;
    entry_t             head;
    entry_t             in_ent;

    function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // No pop credit on a full buffer keeps out_ready off the in_ready path.
    always_comb begin
        full      = (occ_q == 3'(DEPTH));
        in_ready  = rst && !full && !flush;
        out_valid = (occ_q != 3'd0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready && !flush;
        in_ent    = '{in_wd, in_wreg, in_wdata, in_hi, in_lo, in_whilo};
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({push, pop})
                2'b10:   occ_d = occ_q + 3'd1;
                2'b01:   occ_d = occ_q - 3'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            stall_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            stall_q  <= stall_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_ent;
        end
    end

    always_comb begin
        head      = mem_q[rd_ptr_q];
        occupancy = occ_q;
        stall_cnt = stall_q;
        out_wd    = ADDR_W'(NOP_REG_ADDR);
        out_wreg  = WRITE_DISABLE;
        out_wdata = DATA_W'(ZERO_WORD);
        out_hi    = DATA_W'(ZERO_WORD);
        out_lo    = DATA_W'(ZERO_WORD);
        out_whilo = WRITE_DISABLE;
        if (out_valid) begin
            out_wd    = head.wd;
            out_wreg  = head.wreg;
            out_wdata = head.wdata;
            out_hi    = head.hi;
            out_lo    = head.lo;
            out_whilo = head.whilo;
        end
    end

endmodule

// File: tb/tb_wb_pipe_buf.sv
// Bench: DEPTH=2 and DEPTH=4 instances on shared inputs, each checked
// every cycle against a queue model, plus literal directed checks.
module tb_wb_pipe_buf;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  in_wd = '0;
    logic        in_wreg = 1'b0;
    logic [31:0] in_wdata = '0;
    logic [31:0] in_hi = '0;
    logic [31:0] in_lo = '0;
    logic        in_whilo = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_wreg, a_out_whilo;
    logic [4:0]  a_out_wd;
    logic [31:0] a_out_wdata, a_out_hi, a_out_lo;
    logic [2:0]  a_occ;
    logic [15:0] a_stall;

    logic        b_in_ready, b_out_valid, b_out_wreg, b_out_whilo;
    logic [4:0]  b_out_wd;
    logic [31:0] b_out_wdata, b_out_hi, b_out_lo;
    logic [2:0]  b_occ;
    logic [15:0] b_stall;

    wb_pipe_buf #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
        .in_hi(in_hi), .in_lo(in_lo), .in_whilo(in_whilo),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_wd(a_out_wd), .out_wreg(a_out_wreg),
        .out_wdata(a_out_wdata), .out_hi(a_out_hi),
        .out_lo(a_out_lo), .out_whilo(a_out_whilo),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    wb_pipe_buf #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
        .in_hi(in_hi), .in_lo(in_lo), .in_whilo(in_whilo),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_wd(b_out_wd), .out_wreg(b_out_wreg),
        .out_wdata(b_out_wdata), .out_hi(b_out_hi),
        .out_lo(b_out_lo), .out_whilo(b_out_whilo),
        .occupancy(b_occ), .stall_cnt(b_stall)
    );

    always #5 clk = ~clk;

    int    n_pass = 0;
    int    n_tot  = 0;
    ent_t  q2[$];
    ent_t  q4[$];
    int    st2 = 0;
    int    st4 = 0;
    bit    pushed4 = 0;
    bit    log_en = 0;
    int    obs[$];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic chk_inst(string p, int d, int sz, ent_t h, int st,
                            logic ir, logic ov, logic [2:0] occ,
                            logic [15:0] sc, ent_t o);
        ent_t e;
        e = (sz != 0) ? h : '0;
        chk({p, ".in_ready"}, ir, rst && (sz < d) && !flush);
        chk({p, ".out_valid"}, ov, sz != 0);
        chk({p, ".occupancy"}, occ, sz);
        chk({p, ".stall_cnt"}, sc, st);
        chk({p, ".payload"}, o, e);
    endtask

    task automatic check_all();
        ent_t h2, h4, o2, o4;
        h2 = (q2.size() != 0) ? q2[0] : '0;
        h4 = (q4.size() != 0) ? q4[0] : '0;
        o2 = '{a_out_wd, a_out_wreg, a_out_wdata, a_out_hi,
               a_out_lo, a_out_whilo};
        o4 = '{b_out_wd, b_out_wreg, b_out_wdata, b_out_hi,
               b_out_lo, b_out_whilo};
        chk_inst("d2", 2, q2.size(), h2, st2, a_in_ready,
                 a_out_valid, a_occ, a_stall, o2);
        chk_inst("d4", 4, q4.size(), h4, st4, b_in_ready,
                 b_out_valid, b_occ, b_stall, o4);
    endtask

    task automatic model_q(inout ent_t q[$], inout int st,
                           input int d, output bit pushed);
        ent_t cur;
        bit   ov;
        cur    = '{in_wd, in_wreg, in_wdata, in_hi, in_lo, in_whilo};
        pushed = 0;
        if (!rst) begin
            q.delete();
            st = 0;
            return;
        end
        ov = q.size() != 0;
        if (ov && !out_ready && st < 65535) st++;
        if (flush) begin
            q.delete();
        end else begin
            pushed = in_valid && (q.size() < d);
            if (ov && out_ready) void'(q.pop_front());
            if (pushed) q.push_back(cur);
        end
    endtask

    task automatic tick();
        bit dummy;
        if (log_en && b_out_valid && out_ready && !flush)
            obs.push_back(int'(b_out_wdata));
        @(posedge clk);
        model_q(q2, st2, 2, dummy);
        model_q(q4, st4, 4, pushed4);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_in();
        flush = 0; in_valid = 0; out_ready = 0;
        in_wd = '0; in_wreg = 0; in_wdata = '0;
        in_hi = '0; in_lo = '0; in_whilo = 0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    task automatic put(logic [4:0] wd, logic [31:0] wdata);
        in_valid = 1; in_wd = wd; in_wreg = 1; in_wdata = wdata;
        in_hi = wdata ^ 32'hFFFF_0000; in_lo = wdata + 32'd7;
        in_whilo = wdata[0];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cyc;
        @(negedge clk);
        check_all();
        do_reset();

        // single pass
        put(5'd5, 32'h1234); in_hi = '0; in_lo = '0; in_whilo = 0;
        out_ready = 1;
        tick();
        chk("single.valid", a_out_valid, 1'b1);
        chk("single.wd", a_out_wd, 5'd5);
        chk("single.wdata", a_out_wdata, 32'h1234);
        chk("single.wreg", a_out_wreg, 1'b1);
        in_valid = 0;
        tick();
        chk("single.bubble_valid", a_out_valid, 1'b0);
        chk("single.bubble_wdata", a_out_wdata, 32'h0);
        chk("single.bubble_wreg", a_out_wreg, 1'b0);

        // backpressure at DEPTH=2
        do_reset();
        out_ready = 0;
        put(5'd1, 32'hA1); tick();
        put(5'd2, 32'hA2); tick();
        chk("bp.head_stable", a_out_wdata, 32'hA1);
        put(5'd3, 32'hA3); tick();
        chk("bp.occ", a_occ, 3'd2);
        chk("bp.in_ready", a_in_ready, 1'b0);
        chk("bp.stall", a_stall, 16'd2);
        chk("bp.head", a_out_wdata, 32'hA1);

        // full buffer, push+pop offered: pop only
        put(5'd4, 32'hA4); out_ready = 1; tick();
        chk("fullpp.occ", a_occ, 3'd1);
        chk("fullpp.head", a_out_wdata, 32'hA2);
        put(5'd5, 32'hA5); out_ready = 0; tick();
        chk("refill.occ", a_occ, 3'd2);
        chk("refill.stall", a_stall, 16'd3);

        // flush with offered entry
        flush = 1; put(5'd6, 32'hA6); out_ready = 1;
        #1 chk("flush.in_ready", a_in_ready, 1'b0);
        tick();
        chk("flush.occ", a_occ, 3'd0);
        chk("flush.valid", a_out_valid, 1'b0);
        chk("flush.stall", a_stall, 16'd3);
        flush = 0; in_valid = 0; tick();
        chk("flush.dropped", a_occ, 3'd0);

        // async reset between edges
        do_reset();
        out_ready = 0;
        put(5'd7, 32'hB1); tick();
        put(5'd8, 32'hB2); tick();
        in_valid = 0;
        chk("arst.pre_occ", a_occ, 3'd2);
        #2 rst = 0;
        #1;
        chk("arst.occ", a_occ, 3'd0);
        chk("arst.wreg", a_out_wreg, 1'b0);
        chk("arst.stall", a_stall, 16'd0);
        chk("arst.in_ready", a_in_ready, 1'b0);
        tick();
        rst = 1;
        tick();

        // wrap-around at DEPTH=4
        do_reset();
        obs.delete();
        log_en = 1;
        idx = 1;
        put(5'd1, 32'd1);
        cyc = 0;
        while (idx <= 10 && cyc < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (pushed4) begin
                idx++;
                if (idx <= 10) put(5'(idx), 32'(idx));
                else in_valid = 0;
            end
            cyc++;
        end
        in_valid = 0;
        cyc = 0;
        while (obs.size() < 10 && cyc < 100) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        log_en = 0;
        chk("wrap.count", obs.size(), 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("wrap.order%0d", i),
                (i < obs.size()) ? obs[i] : -1, i + 1);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            flush = ($urandom_range(0, 15) == 0);
            in_valid = ($urandom_range(0, 9) < 6);
            in_wd = 5'($urandom); in_wreg = 1'($urandom);
            in_wdata = $urandom; in_hi = $urandom;
            in_lo = $urandom; in_whilo = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 5);
            tick();
        end

        // stall counter saturation
        do_reset();
        put(5'd9, 32'hC1); out_ready = 0;
        tick();
        in_valid = 0;
        for (int i = 0; i < 65540; i++) tick();
        chk("sat.stall", a_stall, 16'hFFFF);
        chk("sat.stall_d4", b_stall, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
